// File: rtl/m6809_sys_pkg.sv
// Shared constants and types for the 6809 system-card glue logic: address map,
// control-register layout and the MRDY wait-state machine encoding.
package m6809_sys_pkg;

  localparam logic [15:0] RAM_TOP   = 16'hBFFF;
  localparam logic [1:0]  WIN_SEL   = 2'b10;   // A[15:14] of the banked 0x8000-0xBFFF window
  localparam logic [7:0]  UART_OFS  = 8'h00;   // 16-byte UART block at IO_PAGE:00-0F
  localparam logic [7:0]  CTRL_OFS  = 8'h10;
  localparam logic [7:0]  VEC_OFS   = 8'hE0;   // IO_PAGE:E0-FF falls back to ROM/RAM

  localparam int          CTRL_ROMDIS = 7;
  localparam int          CTRL_BANK_HI = 2;
  localparam logic [7:0]  CTRL_MASK = 8'h87;   // bits [6:3] read back as 0

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_COUNT = 2'd1,
    W_DONE  = 2'd2
  } wait_state_e;

endpackage

// File: rtl/m6809_edge_sync.sv
// Two-flop synchroniser for a CPU clock sampled by the system clock, with a single
// one-CLK edge pulse (rising or falling, chosen by RISING) taken from the synced level.
module m6809_edge_sync #(
  parameter logic RISING = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic edge_o
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  assign sh_d = {sh_q[1:0], async_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sh_q <= '0;
    else         sh_q <= sh_d;
  end

  // sh_q[1] is the synchronised level; sh_q[2] is its previous value.
  assign edge_o = RISING ? (sh_q[1] & ~sh_q[2]) : (~sh_q[1] & sh_q[2]);

endmodule

// File: rtl/m6809_sys_decode.sv
// 6809 system-card glue: vector remap of A8, chip selects, RAM banking, strobes,
// the bank/ROM-disable control register and the MRDY wait-state generator.
module m6809_sys_decode
  import m6809_sys_pkg::*;
#(
  parameter int         UART_WAIT = 4,
  parameter int         ROM_WAIT  = 0,
  parameter logic [7:0] IO_PAGE   = 8'hFE
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic        ECLK,
  input  logic        QCLK,
  input  logic [15:0] A,
  input  logic        RNW,
  input  logic        BS,
  input  logic        BA,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic        A8SYS,
  output logic        CSRAM_B,
  output logic        CSROM_B,
  output logic        CSUART_B,
  output logic [2:0]  RAM_BANK,
  output logic        OE_B,
  output logic        WE_B,
  output logic        MRDY_LO,
  output logic [1:0]  WAIT_ST
);

  localparam int WMAX = (UART_WAIT > ROM_WAIT) ? UART_WAIT : ROM_WAIT;
  localparam int CW   = (WMAX < 1) ? 1 : $clog2(WMAX + 1);
  localparam logic [CW-1:0] UART_LD = CW'((UART_WAIT > 0) ? UART_WAIT - 1 : 0);
  localparam logic [CW-1:0] ROM_LD  = CW'((ROM_WAIT > 0) ? ROM_WAIT - 1 : 0);

  logic e_fall, q_rise;

  m6809_edge_sync #(.RISING(1'b0)) u_esync (
    .clk_i(CLK), .rst_ni(RESET_B), .async_i(ECLK), .edge_o(e_fall)
  );
  m6809_edge_sync #(.RISING(1'b1)) u_qsync (
    .clk_i(CLK), .rst_ni(RESET_B), .async_i(QCLK), .edge_o(q_rise)
  );

  // Vector fetches (BS & !BA) flip A8 so FFFx lands at IO_PAGE:Fx.
  logic [15:0] addr;
  assign A8SYS = A[8] ^ (BS & ~BA);
  assign addr  = {A[15:9], A8SYS, A[7:0]};

  logic [7:0] ctrl_q, ctrl_d;
  logic       romdis;
  logic       io_pg, lo_ram, io_rng, rom_area;
  logic       uart_sel, ctrl_sel, rom_sel, ram_sel, any_cs;

  assign romdis   = ctrl_q[CTRL_ROMDIS];
  assign io_pg    = (addr[15:8] == IO_PAGE);
  assign lo_ram   = (addr <= RAM_TOP);
  assign io_rng   = io_pg & (addr[7:0] < VEC_OFS);
  assign rom_area = ~lo_ram & ~io_rng;

  assign uart_sel = ~BA & io_pg & (addr[7:4] == UART_OFS[7:4]);
  assign ctrl_sel = ~BA & io_pg & (addr[7:0] == CTRL_OFS);
  // Writes into the ROM area always shadow into RAM.
  assign rom_sel  = ~BA & rom_area & ~romdis & RNW;
  assign ram_sel  = ~BA & (lo_ram | (rom_area & (romdis | ~RNW)));
  assign any_cs   = ram_sel | rom_sel | uart_sel;

  assign CSRAM_B  = ~ram_sel;
  assign CSROM_B  = ~rom_sel;
  assign CSUART_B = ~uart_sel;
  assign RAM_BANK = (addr[15:14] == WIN_SEL) ? ctrl_q[CTRL_BANK_HI:0] : 3'd0;
  assign OE_B     = ~(RNW & ECLK & any_cs);
  assign WE_B     = ~(~RNW & ECLK & ram_sel);

  assign D_OUT = ctrl_q;
  assign D_OE  = RESET_B & ctrl_sel & RNW & ECLK;

  always_comb begin
    ctrl_d = ctrl_q;
    if (e_fall && ctrl_sel && !RNW) ctrl_d = D_IN & CTRL_MASK;
  end

  // Wait-state machine: request MRDY as soon as a slow device decodes, keep it
  // for N CLKs after the synced Q rise, then release until the cycle ends on E fall.
  wait_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          slow_uart, slow_rom, slow, mrdy;

  assign slow_uart = uart_sel & (UART_WAIT > 0);
  assign slow_rom  = rom_sel & (ROM_WAIT > 0);
  assign slow      = slow_uart | slow_rom;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mrdy    = 1'b0;
    case (state_q)
      W_IDLE: begin
        mrdy = slow;
        if (q_rise && slow) begin
          state_d = W_COUNT;
          cnt_d   = slow_uart ? UART_LD : ROM_LD;
        end
      end
      W_COUNT: begin
        if (!slow) begin
          state_d = W_IDLE;
        end else begin
          mrdy = 1'b1;
          if (cnt_q == '0) state_d = W_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      W_DONE: begin
        if (e_fall) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      ctrl_q  <= 8'h00;
      state_q <= W_IDLE;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by reset so the pad releases immediately, without waiting for a clock.
  assign MRDY_LO = RESET_B & mrdy;
  assign WAIT_ST = state_q;

endmodule

// File: tb/tb_m6809_sys_decode.sv
// Self-checking bench for m6809_sys_decode: fixed scenarios plus randomised decode
// against a reference address-map model, all results checked through an expected queue.
module tb_m6809_sys_decode;

  logic        CLK = 1'b0;
  logic        RESET_B, ECLK, QCLK, RNW, BS, BA;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE, A8SYS, CSRAM_B, CSROM_B, CSUART_B, OE_B, WE_B, MRDY_LO;
  logic [2:0]  RAM_BANK;
  logic [1:0]  WAIT_ST;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;
  logic        romdis_m;
  logic [2:0]  bank_m;

  always #5 CLK = ~CLK;

  m6809_sys_decode #(.UART_WAIT(4), .ROM_WAIT(0), .IO_PAGE(8'hFE)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .ECLK(ECLK), .QCLK(QCLK), .A(A), .RNW(RNW),
    .BS(BS), .BA(BA), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .A8SYS(A8SYS),
    .CSRAM_B(CSRAM_B), .CSROM_B(CSROM_B), .CSUART_B(CSUART_B), .RAM_BANK(RAM_BANK),
    .OE_B(OE_B), .WE_B(WE_B), .MRDY_LO(MRDY_LO), .WAIT_ST(WAIT_ST)
  );

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_bus(input logic [15:0] a, input logic rnw, input logic bs, input logic ba);
    A = a; RNW = rnw; BS = bs; BA = ba;
  endtask

  // Full E/Q cycle writing v to the control register at FE10.
  task automatic ctrl_write(input logic [7:0] v);
    set_bus(16'hFE10, 1'b0, 1'b0, 1'b0);
    D_IN = v; QCLK = 1'b0; ECLK = 1'b0;
    tick(2);
    QCLK = 1'b1; tick(3);
    ECLK = 1'b1; tick(3);
    QCLK = 1'b0; tick(3);
    ECLK = 1'b0; tick(5);
    RNW = 1'b1;
    romdis_m = v[7];
    bank_m   = v[2:0];
  endtask

  function automatic logic [6:0] obs_cs();
    return {CSRAM_B, CSROM_B, CSUART_B, A8SYS, RAM_BANK};
  endfunction

  // Reference address map: {CSRAM_B, CSROM_B, CSUART_B, A8SYS, RAM_BANK}.
  function automatic logic [6:0] map_model(input logic [15:0] a, input logic rnw,
                                           input logic bs, input logic ba);
    logic        a8, ram, rom, uart;
    logic [15:0] ad;
    logic [2:0]  rb;
    a8 = a[8] ^ (bs & !ba);
    ad = {a[15:9], a8, a[7:0]};
    ram = 1'b0; rom = 1'b0; uart = 1'b0;
    if (!ba) begin
      if (ad < 16'hC000)                           ram  = 1'b1;
      else if (ad[15:8] == 8'hFE && ad[7:0] < 8'hE0) uart = (ad[7:0] < 8'h10);
      else if (!romdis_m && rnw)                   rom  = 1'b1;
      else                                         ram  = 1'b1;
    end
    rb = (ad >= 16'h8000 && ad < 16'hC000) ? bank_m : 3'd0;
    return {!ram, !rom, !uart, a8, rb};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET_B = 1'b0; ECLK = 1'b0; QCLK = 1'b0; D_IN = 8'h00;
    set_bus(16'hFFFE, 1'b1, 1'b1, 1'b0);
    romdis_m = 1'b0; bank_m = 3'd0;
    exp_q.push_back(16'(7'b1010000));
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    tick(3);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(obs_cs()) !== exp) begin
      n_fail++; $display("FAIL rst_cs: got %b want %b", obs_cs(), exp[6:0]);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(D_OUT) !== exp) begin
      n_fail++; $display("FAIL rst_ctrl: got %h want %h", D_OUT, exp[7:0]);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (16'({MRDY_LO, D_OE, WAIT_ST}) !== exp) begin
      n_fail++; $display("FAIL rst_wait: got mrdy=%b oe=%b st=%0d want 0", MRDY_LO, D_OE, WAIT_ST);
    end
    tick(1);
    RESET_B = 1'b1;
    tick(2);
  endtask

  task automatic test_ctrl_reg();
    ctrl_write(8'h85);
    set_bus(16'h8000, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(16'd5);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(RAM_BANK) !== exp) begin
      n_fail++; $display("FAIL bank_set: got %0d want %0d", RAM_BANK, exp);
    end
    tick(1);
    set_bus(16'hC123, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(16'b01);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'({CSRAM_B, CSROM_B}) !== exp) begin
      n_fail++; $display("FAIL romdis_rd: got ram_b=%b rom_b=%b want 0/1", CSRAM_B, CSROM_B);
    end
    tick(1);
    set_bus(16'hFE10, 1'b1, 1'b0, 1'b0);
    ECLK = 1'b1;
    exp_q.push_back({8'h85, 6'd0, 1'b1, 1'b1});
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if ({D_OUT, 6'd0, D_OE, OE_B} !== exp) begin
      n_fail++; $display("FAIL ctrl_rd: got dout=%h oe=%b oe_b=%b want 85/1/1", D_OUT, D_OE, OE_B);
    end
    tick(1);
    ECLK = 1'b0;
    exp_q.push_back(16'd0);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(D_OE) !== exp) begin
      n_fail++; $display("FAIL ctrl_oe_elow: got %b want 0", D_OE);
    end
    tick(1);
    ctrl_write(8'hFF);
    exp_q.push_back(16'h0087);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(D_OUT) !== exp) begin
      n_fail++; $display("FAIL ctrl_mask: got %h want %h", D_OUT, exp[7:0]);
    end
    tick(1);
  endtask

  task automatic test_shadow();
    ctrl_write(8'h00);
    set_bus(16'hC123, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'b011);
    exp_q.push_back(16'b0);
    exp_q.push_back(16'b1);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'({CSRAM_B, CSROM_B, WE_B}) !== exp) begin
      n_fail++; $display("FAIL shadow_cs: got ram_b=%b rom_b=%b we_b=%b want 0/1/1", CSRAM_B, CSROM_B, WE_B);
    end
    tick(1); ECLK = 1'b1;
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(WE_B) !== exp) begin
      n_fail++; $display("FAIL shadow_we_hi: got %b want 0", WE_B);
    end
    tick(1); ECLK = 1'b0;
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(WE_B) !== exp) begin
      n_fail++; $display("FAIL shadow_we_lo: got %b want 1", WE_B);
    end
    tick(1);
    RNW = 1'b1; ECLK = 1'b1;
    exp_q.push_back(16'b100);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'({CSRAM_B, CSROM_B, OE_B}) !== exp) begin
      n_fail++; $display("FAIL rom_rd: got ram_b=%b rom_b=%b oe_b=%b want 1/0/0", CSRAM_B, CSROM_B, OE_B);
    end
    tick(1); ECLK = 1'b0;
    ctrl_write(8'h80);
    set_bus(16'hC123, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(16'b01);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'({CSRAM_B, CSROM_B}) !== exp) begin
      n_fail++; $display("FAIL romdis_ram: got ram_b=%b rom_b=%b want 0/1", CSRAM_B, CSROM_B);
    end
    tick(1);
    ctrl_write(8'h00);
  endtask

  task automatic test_wait_uart();
    int hi;
    set_bus(16'hFE03, 1'b1, 1'b0, 1'b0);
    QCLK = 1'b0; ECLK = 1'b0;
    tick(4);
    exp_q.push_back(16'b01);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'({CSUART_B, MRDY_LO}) !== exp) begin
      n_fail++; $display("FAIL uart_req: got cs_b=%b mrdy=%b want 0/1", CSUART_B, MRDY_LO);
    end
    @(posedge CLK); #1;
    QCLK = 1'b1;
    // 2 sync flops + 1 CLK to enter COUNT + 4 counted CLKs.
    exp_q.push_back(16'd7);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (MRDY_LO !== 1'b1) break;
      hi++;
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(hi) !== exp) begin
      n_fail++; $display("FAIL uart_wait_len: got %0d want %0d", hi, exp);
    end
    exp_q.push_back(16'd2);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(WAIT_ST) !== exp) begin
      n_fail++; $display("FAIL uart_done_st: got %0d want %0d", WAIT_ST, exp);
    end
    @(posedge CLK); #1;
    ECLK = 1'b1;
    tick(4);
    exp_q.push_back(16'd0);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(MRDY_LO) !== exp) begin
      n_fail++; $display("FAIL uart_done_hold: got %b want 0", MRDY_LO);
    end
    @(posedge CLK); #1;
    ECLK = 1'b0;
    tick(4);
    exp_q.push_back({13'd0, 2'd0, 1'b1});
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if ({13'd0, WAIT_ST, MRDY_LO} !== exp) begin
      n_fail++; $display("FAIL uart_rereq: got st=%0d mrdy=%b want 0/1", WAIT_ST, MRDY_LO);
    end
    tick(1);
    QCLK = 1'b0;
    set_bus(16'h1000, 1'b1, 1'b0, 1'b0);
    tick(4);
  endtask

  task automatic test_wait_abort();
    set_bus(16'hFE03, 1'b1, 1'b0, 1'b0);
    tick(4);
    QCLK = 1'b1;
    tick(4);
    BA = 1'b1;
    exp_q.push_back(16'b1110);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'({CSRAM_B, CSROM_B, CSUART_B, MRDY_LO}) !== exp) begin
      n_fail++; $display("FAIL abort_ba: got %b want %b", {CSRAM_B, CSROM_B, CSUART_B, MRDY_LO}, exp[3:0]);
    end
    tick(1);
    exp_q.push_back(16'd0);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(WAIT_ST) !== exp) begin
      n_fail++; $display("FAIL abort_idle: got %0d want 0", WAIT_ST);
    end
    tick(1);
    BA = 1'b0; QCLK = 1'b0;
    ctrl_write(8'h83);
    set_bus(16'hFE03, 1'b1, 1'b0, 1'b0);
    tick(4);
    QCLK = 1'b1;
    tick(4);
    exp_q.push_back(16'd1);
    @(negedge CLK);
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(WAIT_ST) !== exp) begin
      n_fail++; $display("FAIL rst_pre_count: got %0d want 1", WAIT_ST);
    end
    @(posedge CLK); #2;
    RESET_B = 1'b0;
    romdis_m = 1'b0; bank_m = 3'd0;
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (16'({MRDY_LO, WAIT_ST}) !== exp) begin
      n_fail++; $display("FAIL rst_mid_mrdy: got mrdy=%b st=%0d want 0/0", MRDY_LO, WAIT_ST);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (16'(D_OUT) !== exp) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got %h want 00", D_OUT);
    end
    QCLK = 1'b0;
    tick(3);
    RESET_B = 1'b1;
    tick(2);
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic        rnw, bs, ba;
    logic [6:0]  cs;   // {CSRAM_B, CSROM_B, CSUART_B, A8SYS, RAM_BANK}
  } map_vec_t;

  task automatic test_map();
    map_vec_t tbl[15];
    tbl[0]  = '{16'h9000, 1'b1, 1'b0, 1'b0, 7'b0110011};
    tbl[1]  = '{16'h1000, 1'b1, 1'b0, 1'b0, 7'b0110000};
    tbl[2]  = '{16'hFE40, 1'b1, 1'b0, 1'b0, 7'b1110000};
    tbl[3]  = '{16'hBFFF, 1'b1, 1'b0, 1'b0, 7'b0111011};
    tbl[4]  = '{16'hC000, 1'b1, 1'b0, 1'b0, 7'b1010000};
    tbl[5]  = '{16'hFE0F, 1'b1, 1'b0, 1'b0, 7'b1100000};
    tbl[6]  = '{16'hFE10, 1'b1, 1'b0, 1'b0, 7'b1110000};
    tbl[7]  = '{16'hFEDF, 1'b1, 1'b0, 1'b0, 7'b1110000};
    tbl[8]  = '{16'hFEE0, 1'b1, 1'b0, 1'b0, 7'b1010000};
    tbl[9]  = '{16'hFFFE, 1'b1, 1'b1, 1'b0, 7'b1010000};
    tbl[10] = '{16'hFFFE, 1'b1, 1'b1, 1'b1, 7'b1111000};
    tbl[11] = '{16'hFEF0, 1'b1, 1'b1, 1'b0, 7'b1011000};
    tbl[12] = '{16'h7FFF, 1'b1, 1'b0, 1'b0, 7'b0111000};
    tbl[13] = '{16'h8000, 1'b1, 1'b0, 1'b0, 7'b0110011};
    tbl[14] = '{16'hC123, 1'b0, 1'b0, 1'b0, 7'b0111000};
    ctrl_write(8'h03);
    for (int i = 0; i < 15; i++) begin
      set_bus(tbl[i].a, tbl[i].rnw, tbl[i].bs, tbl[i].ba);
      exp_q.push_back(16'(tbl[i].cs));
      @(negedge CLK);
      exp = exp_q.pop_front(); n_cmp++;
      if (16'(obs_cs()) !== exp) begin
        n_fail++; $display("FAIL map_%0d a=%h: got %b want %b", i, tbl[i].a, obs_cs(), exp[6:0]);
      end
      tick(1);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic        rnw, bs, ba;
    ctrl_write(8'h86);
    for (int i = 0; i < 60; i++) begin
      if (i == 30) ctrl_write(8'h02);
      a = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) a[15:9] = 7'h7F;
      rnw = 1'($urandom_range(0, 1));
      bs  = 1'($urandom_range(0, 1));
      ba  = ($urandom_range(0, 7) == 0);
      set_bus(a, rnw, bs, ba);
      exp_q.push_back(16'(map_model(a, rnw, bs, ba)));
      @(negedge CLK);
      exp = exp_q.pop_front(); n_cmp++;
      if (16'(obs_cs()) !== exp) begin
        n_fail++; $display("FAIL rand_%0d a=%h rnw=%b bs=%b ba=%b: got %b want %b",
                           i, a, rnw, bs, ba, obs_cs(), exp[6:0]);
      end
      tick(1);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_reg();
    test_shadow();
    test_wait_uart();
    test_wait_abort();
    test_map();
    test_random();
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
